unmask3_serial: RTL
===================

UNMASK3_SERIAL -- requirements
Module: unmask3_serial

Interface
REQ-001 SHALL provide parameter: W, default 8, data width of each share and of the recombined word.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: in_valid  input  1  share triple on is0/is1/is2 is valid.
REQ-005 SHALL provide port: in_ready  output  1  block accepts a share triple this cycle.
REQ-006 SHALL provide port: is0  input  W  share 0 of masked word.
REQ-007 SHALL provide port: is1  input  W  share 1 of masked word.
REQ-008 SHALL provide port: is2  input  W  share 2 of masked word.
REQ-009 SHALL provide port: out_valid  output  1  out_data holds the recombined word.
REQ-010 SHALL provide port: out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL provide port: out_data  output  W  unmasked word, is0^is1^is2.
REQ-012 SHALL provide port: busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, S0, S1, S2, OUT.
REQ-014 SHALL assert in_ready only in IDLE; an input handshake is in_valid & in_ready.
REQ-015 SHALL, on an input handshake, capture is0, is1 and is2 into three separate share registers and move to S0.
REQ-016 SHALL, in S0, load acc with share register 0 and move to S1.
REQ-017 SHALL, in S1, update acc to acc ^ share register 1 and move to S2.
REQ-018 SHALL, in S2, update acc to acc ^ share register 2, clear all three share registers to zero, and move to OUT.
REQ-019 SHALL never combine two or more shares in one combinational cone; each XOR takes exactly one share register and acc.
REQ-020 SHALL assert out_valid only in OUT and drive out_data = acc in OUT and all-zero in every other state.
REQ-021 SHALL hold out_data and out_valid stable in OUT until out_ready is high.
REQ-022 SHALL, on an output handshake, clear acc to zero and return to IDLE; the next input is accepted no earlier than the following cycle.
REQ-023 SHALL raise out_valid exactly 4 cycles after the input-handshake edge: handshake in cycle k, out_valid in cycle k+4.
REQ-024 SHALL sustain at most one word every 5 cycles when out_ready is held high.
REQ-025 SHALL ignore in_valid and is0..is2 in all states other than IDLE.
REQ-026 SHALL ignore out_ready in all states other than OUT.
REQ-027 SHALL perform all arithmetic bitwise XOR on W bits, with no carries and no width extension.

Reset
REQ-028 SHALL, while rst is high, force state IDLE, acc zero, all share registers zero, out_valid 0, out_data zero and busy 0.
REQ-029 SHALL drive in_ready 0 while rst is high.
REQ-030 SHALL, on rst asserted in any state, abort the operation in progress and discard its word; no out_valid is produced for it.
REQ-031 SHALL give rst priority over simultaneous input or output handshakes.

Structure
REQ-032 SHALL place in a shared masking package: the FSM state enum, N_SHARES = 3 and the default width constant.
REQ-033 SHALL instantiate the sub-module share_reg three times, one per share: a W-bit register with synchronous load and clear.

Verification
REQ-034 SHALL cover basic unmask: W=8, is0=8'hA5, is1=8'h3C, is2=8'h0F, out_ready=1 -> out_data=8'h96 with out_valid high in cycle k+4 only.
REQ-035 SHALL cover backpressure: out_ready=0 for 6 cycles in OUT -> out_valid and out_data=8'h96 held stable; in_ready=0 throughout; handshake on the 7th cycle -> IDLE.
REQ-036 SHALL cover ignored input: in_valid=1 with shares 8'hFF,8'h00,8'h00 presented during S1 -> current result unchanged and the new triple is not captured.
REQ-037 SHALL cover reset mid-operation: rst pulsed in S1 -> in the next cycle all outputs are zero and no out_valid is produced for the aborted word.
REQ-038 SHALL cover residue clearing: after S2, all share registers read zero (white-box), and after the output handshake acc reads zero.
REQ-039 SHALL cover back-to-back traffic: 100 random triples with in_valid and out_ready held high -> each out_data equals is0^is1^is2 and words are spaced exactly 5 cycles apart.

Source files
------------

// File: rtl/unmask3_serial_pkg.sv
// Shared masking definitions: FSM state encoding, share count and default width
// used by the serial three-share recombiner and its share registers.
package unmask3_serial_pkg;

    localparam int N_SHARES  = 3;
    localparam int DEFAULT_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        OUT  = 3'd4
    } unmask_state_t;

endpackage

// File: rtl/unmask3_serial_share_reg.sv
// One masked share held in isolation: synchronous load, synchronous clear.
// Clear wins over load so residue can never survive a clear request.
module share_reg
    import unmask3_serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/unmask3_serial.sv
// Serial unmasking of a three-share word: each share is folded into the
// accumulator in its own cycle so no two shares ever meet in one logic cone.
module unmask3_serial
    import unmask3_serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] is0,
    input  logic [W-1:0] is1,
    input  logic [W-1:0] is2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    unmask_state_t               state_reg;
    logic [W-1:0]                acc_reg;
    logic                        in_ready_reg;
    logic                        out_valid_reg;
    logic                        busy_reg;

    logic [N_SHARES-1:0][W-1:0]  share_d;
    logic [N_SHARES-1:0][W-1:0]  share_q;
    logic                        in_fire;
    logic                        out_fire;
    logic                        share_clr;

    // Outputs are masked by rst so they read idle during the reset cycle itself.
    assign in_ready  = in_ready_reg  & ~rst;
    assign out_valid = out_valid_reg & ~rst;
    assign busy      = busy_reg      & ~rst;
    assign out_data  = out_valid ? acc_reg : '0;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign share_clr = (state_reg == S2);
    assign share_d   = {is2, is1, is0};

    generate
        for (genvar gi = 0; gi < N_SHARES; gi++) begin : g_share
            share_reg #(
                .W (W)
            ) u_share (
                .clk  (clk),
                .srst (rst),
                .load (in_fire),
                .clr  (share_clr),
                .d    (share_d[gi]),
                .q    (share_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_fire) begin
                        state_reg    <= S0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                S0: begin
                    acc_reg   <= share_q[0];
                    state_reg <= S1;
                end
                S1: begin
                    acc_reg   <= acc_reg ^ share_q[1];
                    state_reg <= S2;
                end
                S2: begin
                    acc_reg       <= acc_reg ^ share_q[2];
                    out_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    // Wipe the unmasked value as soon as it has been consumed.
                    if (out_fire) begin
                        acc_reg       <= '0;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    acc_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule
